// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG output byte stuffer: marker bytes, FSM state
// encoding and the residual-byte count helper.
package jpeg_pkg;

  localparam logic [7:0] JPG_MARKER = 8'hFF;
  localparam logic [7:0] JPG_STUFF  = 8'h00;
  localparam logic [7:0] JPG_EOI_LO = 8'hD9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    STUFF,
    FLUSH,
    EOI_FF,
    EOI_D9
  } state_t;

  // ceil(bits/8) for a 0..31 bit residual; result is 0..4.
  function automatic logic [2:0] flush_nbytes(input logic [5:0] bits);
    logic [6:0] sum;
    sum = {1'b0, bits} + 7'd7;
    return sum[5:3];
  endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// Synchronous DEPTH x 32 word FIFO. A push while full is accepted only if a pop
// happens in the same cycle; a pop while empty is ignored.
module jpeg_word_fifo #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Serialises packed 32-bit JPEG words MSB-byte-first with 0xFF/0x00 stuffing,
// then on end-of-image emits the 1-padded residual and the FF D9 marker.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        word_en,
  input  logic [31:0] word_in,
  input  logic        flush,
  input  logic [31:0] flush_word,
  input  logic [5:0]  flush_bits,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_out,
  output logic        almost_full,
  output logic        ovf_err,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  state_t      state;
  logic [31:0] shreg;
  logic [1:0]  bcnt;
  logic        in_flush;
  logic        flush_pend;
  logic [31:0] fl_word;
  logic [2:0]  fl_nb;

  logic [31:0] fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        fifo_pop;

  logic        xfer;
  logic        data_state;
  logic        advance;

  jpeg_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (word_en),
    .pop   (fifo_pop),
    .din   (word_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign xfer       = byte_valid & byte_ready;
  assign data_state = (state == EMIT) || (state == FLUSH);
  // Move to the next byte unless the byte just sent was 0xFF and needs a stuff byte.
  assign advance    = xfer && ((state == STUFF) || (data_state && byte_out != JPG_MARKER));
  // Back-to-back words: the last byte's transfer pops the next word without a bubble.
  assign fifo_pop   = (state == LOAD) ||
                      (advance && !in_flush && bcnt == 2'd0 && !fifo_empty);

  assign almost_full = (fifo_count >= (AW+1)'(DEPTH - 2));
  assign busy        = !fifo_empty || (state != IDLE) || flush_pend;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      shreg      <= '0;
      bcnt       <= '0;
      in_flush   <= 1'b0;
      flush_pend <= 1'b0;
      fl_word    <= '0;
      fl_nb      <= '0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      ovf_err    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (flush && !flush_pend) begin
        flush_pend <= 1'b1;
        fl_word    <= flush_word | (32'hFFFF_FFFF >> flush_bits);
        fl_nb      <= flush_nbytes(flush_bits);
      end

      if (word_en && fifo_full && !fifo_pop) ovf_err <= 1'b1;

      if (fifo_pop) begin
        byte_out   <= fifo_dout[31:24];
        shreg      <= {fifo_dout[23:0], 8'h00};
        bcnt       <= 2'd3;
        byte_valid <= 1'b1;
        state      <= EMIT;
      end else if (advance) begin
        if (bcnt != 2'd0) begin
          byte_out <= shreg[31:24];
          shreg    <= {shreg[23:0], 8'h00};
          bcnt     <= bcnt - 2'd1;
          state    <= in_flush ? FLUSH : EMIT;
        end else if (in_flush) begin
          byte_out <= JPG_MARKER;
          state    <= EOI_FF;
        end else begin
          byte_valid <= 1'b0;
          state      <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            // Words already queued (or arriving now) go out before the residual.
            if (!fifo_empty || word_en) begin
              state <= LOAD;
            end else if (flush_pend) begin
              in_flush   <= 1'b1;
              byte_valid <= 1'b1;
              if (fl_nb == 3'd0) begin
                byte_out <= JPG_MARKER;
                state    <= EOI_FF;
              end else begin
                byte_out <= fl_word[31:24];
                shreg    <= {fl_word[23:0], 8'h00};
                bcnt     <= 2'(fl_nb - 3'd1);
                state    <= FLUSH;
              end
            end
          end
          EMIT, FLUSH: begin
            if (xfer) begin
              byte_out <= JPG_STUFF;
              state    <= STUFF;
            end
          end
          EOI_FF: begin
            if (xfer) begin
              byte_out <= JPG_EOI_LO;
              state    <= EOI_D9;
            end
          end
          EOI_D9: begin
            if (xfer) begin
              byte_valid <= 1'b0;
              done       <= 1'b1;
              in_flush   <= 1'b0;
              flush_pend <= 1'b0;
              state      <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench for jpeg_byte_stuffer: pass-through, stuffing, backpressure,
// overflow, flush/EOI and mid-stream reset, with hand-computed byte streams.
module tb_jpeg_byte_stuffer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        word_en;
  logic [31:0] word_in;
  logic        flush;
  logic [31:0] flush_word;
  logic [5:0]  flush_bits;
  logic        byte_ready;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic        almost_full;
  logic        ovf_err;
  logic        busy;
  logic        done;

  jpeg_byte_stuffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .word_en     (word_en),
    .word_in     (word_in),
    .flush       (flush),
    .flush_word  (flush_word),
    .flush_bits  (flush_bits),
    .byte_ready  (byte_ready),
    .byte_valid  (byte_valid),
    .byte_out    (byte_out),
    .almost_full (almost_full),
    .ovf_err     (ovf_err),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         c;
  } rec_t;

  rec_t mon_q[$];
  int   cyc      = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] ov_words [6] = '{32'h10111213, 32'h20212223, 32'h30313233,
                                32'h40414243, 32'h50515253, 32'h60616263};

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recorded mid-cycle, one record per accepted byte.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) mon_q.push_back('{b: byte_out, c: cyc});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_byte"},  32'(byte_out),   32'h00);
    check({tag, "_af"},    32'(almost_full), 32'd0);
    check({tag, "_ovf"},   32'(ovf_err),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || byte_valid) && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 400), 32'd1);
    repeat (2) tick();
  endtask

  // Expected bytes are right-aligned in v, first byte most significant.
  task automatic expect_bytes(input string tag, input int start, input int n,
                              input logic [127:0] v);
    check({tag, "_len"}, 32'(mon_q.size() - start), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (start + i < mon_q.size())
        check($sformatf("%s_b%0d", tag, i), 32'(mon_q[start+i].b),
              32'(v[8*(n-1-i) +: 8]));
    end
  endtask

  task automatic expect_contig(input string tag, input int start);
    int last = mon_q.size() - 1;
    if (last > start)
      check({tag, "_gap"}, 32'(mon_q[last].c - mon_q[start].c), 32'(last - start));
  endtask

  task automatic send_word(input logic [31:0] w);
    word_en = 1'b1;
    word_in = w;
    tick();
    word_en = 1'b0;
  endtask

  task automatic do_flush(input string tag, input logic [31:0] fw, input logic [5:0] fb,
                          input int n, input logic [127:0] v);
    int s = mon_q.size();
    int d = done_cnt;
    flush      = 1'b1;
    flush_word = fw;
    flush_bits = fb;
    tick();
    flush = 1'b0;
    wait_idle(tag);
    expect_bytes(tag, s, n, v);
    expect_contig(tag, s);
    check({tag, "_done_cnt"}, 32'(done_cnt - d), 32'd1);
    if (mon_q.size() > s)
      check({tag, "_done_cyc"}, 32'(done_cyc), 32'(mon_q[mon_q.size()-1].c + 1));
  endtask

  initial begin
    int s;
    int c;

    nrst       = 1'b0;
    word_en    = 1'b0;
    word_in    = '0;
    flush      = 1'b0;
    flush_word = '0;
    flush_bits = '0;
    byte_ready = 1'b1;
    repeat (3) tick();
    check_reset("rst");
    nrst = 1'b1;
    tick();
    check_reset("rst_rel");

    // Pass-through with first-byte latency of two cycles.
    s = mon_q.size();
    c = cyc;
    send_word(32'h12345678);
    wait_idle("pass");
    expect_bytes("pass", s, 4, 128'h12345678);
    expect_contig("pass", s);
    if (mon_q.size() > s) check("pass_latency", 32'(mon_q[s].c), 32'(c + 2));
    check("pass_busy", 32'(busy), 32'd0);

    // Stuffing, with the next word following with no idle cycle.
    s = mon_q.size();
    send_word(32'hFF00FFAB);
    send_word(32'h01020304);
    wait_idle("stuff");
    expect_bytes("stuff", s, 10, 128'hFF0000FF00AB01020304);
    expect_contig("stuff", s);

    // Backpressure: ready low for 3 cycles right after FE is accepted.
    s = mon_q.size();
    send_word(32'hCAFEBABE);
    repeat (3) tick();
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", i), 32'(byte_valid), 32'd1);
      check($sformatf("bp_hold%0d", i), 32'(byte_out), 32'hBA);
      tick();
    end
    byte_ready = 1'b1;
    wait_idle("bp");
    expect_bytes("bp", s, 4, 128'hCAFEBABE);

    // Overflow: six writes into a depth-4 FIFO with the output stalled.
    s = mon_q.size();
    byte_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      word_en = 1'b1;
      word_in = ov_words[k-1];
      tick();
      check($sformatf("ovf_af_w%0d", k),  32'(almost_full), 32'(k >= 3));
      check($sformatf("ovf_err_w%0d", k), 32'(ovf_err),     32'(k == 6));
    end
    word_en    = 1'b0;
    byte_ready = 1'b1;
    wait_idle("ovf");
    check("ovf_len", 32'(mon_q.size() - s), 32'd20);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (s + 4*w + b < mon_q.size())
          check($sformatf("ovf_w%0d_b%0d", w, b), 32'(mon_q[s+4*w+b].b),
                32'(ov_words[w][8*(3-b) +: 8]));
      end
    end
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    check("ovf_af_drain", 32'(almost_full), 32'd0);

    // Flush cases: residual padded with 1s, stuffing, then FF D9.
    do_flush("fl12", 32'hABC00000, 6'd12, 4, 128'hABCFFFD9);
    do_flush("fl0",  32'h00000000, 6'd0,  2, 128'hFFD9);
    do_flush("fl8",  32'hFF000000, 6'd8,  4, 128'hFF00FFD9);

    // A word and a flush in the same cycle: the word goes first.
    s = mon_q.size();
    word_en    = 1'b1;
    word_in    = 32'h55667788;
    flush      = 1'b1;
    flush_word = 32'h0;
    flush_bits = 6'd0;
    tick();
    word_en = 1'b0;
    flush   = 1'b0;
    wait_idle("wfl");
    expect_bytes("wfl", s, 6, 128'h55667788FFD9);

    // Reset while the second byte of a word is on the output.
    send_word(32'hAABBCCDD);
    repeat (2) tick();
    check("mid_pre_byte", 32'(byte_out), 32'hBB);
    nrst = 1'b0;
    #1;
    check_reset("mid_rst");
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    s = mon_q.size();
    send_word(32'h11223344);
    wait_idle("post_rst");
    expect_bytes("post_rst", s, 4, 128'h11223344);
    check("post_rst_ovf", 32'(ovf_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
